// File: rtl/stopwatch.sv
// Count-up mm:ss stopwatch with BCD digits, pause/resume, lap freeze and saturation at 99:59.
// Latency: one cycle from command to registered outputs. No backpressure.
module stopwatch #(
   parameter int COUNT = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic       running,
   output logic       lap_active,
   output logic       full
);

   localparam int PW = $clog2(COUNT);
   localparam logic [PW-1:0] PMAX = PW'(COUNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_FULL} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   live_q, live_d;
   logic [15:0]   latch_q, latch_d;
   logic [15:0]   disp_q, disp_d;
   logic          lap_q, lap_d;
   logic          running_q, full_q;
   logic          tick;

   // Digits packed as {min_hi, min_lo, sec_hi, sec_lo}; callers never pass 99:59.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) begin
               r[11:8] = v[11:8] + 4'd1;
            end else begin
               r[11:8]  = 4'd0;
               r[15:12] = v[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      live_d  = live_q;
      latch_d = latch_q;
      lap_d   = lap_q;
      tick    = (presc_q == PMAX);
      if (clear) begin
         state_d = S_IDLE;
         presc_d = '0;
         live_d  = '0;
         lap_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE:  if (start && !stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                     end
            S_RUN:   if (stop) begin
                        state_d = S_PAUSE;
                     end else if (tick) begin
                        presc_d = '0;
                        if (live_q == 16'h9959) state_d = S_FULL;
                        else                    live_d  = bcd_inc(live_q);
                     end else begin
                        presc_d = presc_q + PW'(1);
                     end
            S_PAUSE: if (start && !stop) state_d = S_RUN;
            default: ;
         endcase
         // Freeze captures the pre-increment value when it coincides with a tick.
         if (lap && lap_q) begin
            lap_d = 1'b0;
         end else if (lap && state_q == S_RUN && !stop && !start) begin
            lap_d   = 1'b1;
            latch_d = live_q;
         end
      end
      disp_d = lap_d ? latch_d : live_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         live_q    <= '0;
         latch_q   <= '0;
         disp_q    <= '0;
         lap_q     <= 1'b0;
         running_q <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         live_q    <= live_d;
         latch_q   <= latch_d;
         disp_q    <= disp_d;
         lap_q     <= lap_d;
         running_q <= (state_d == S_RUN);
         full_q    <= (state_d == S_FULL);
      end
   end

   assign {min_hi, min_lo, sec_hi, sec_lo} = disp_q;
   assign running    = running_q;
   assign lap_active = lap_q;
   assign full       = full_q;

endmodule

// File: tb/tb_stopwatch.sv
// Randomized and directed bench for stopwatch against an elapsed-seconds reference model.
module tb_stopwatch;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
   logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
   logic       running, lap_active, full;

   int checks = 0;
   int failures = 0;

   // Model: total elapsed seconds, prescaler cycles, mode, frozen seconds.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;
   int m_total = 0, m_presc = 0, m_mode = M_IDLE, m_frozen = 0;
   bit m_lap = 0;

   stopwatch #(.COUNT(C)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
      .running(running), .lap_active(lap_active), .full(full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] secs_to_digits(input int t);
      int mins, secs;
      mins = t / 60;
      secs = t % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
   endfunction

   task automatic model_step(input bit s, input bit p, input bit c, input bit l, input bit r);
      int  old_total;
      bit  freeze_on;
      old_total = m_total;
      freeze_on = l && !m_lap && m_mode == M_RUN && !p && !s && !c;
      if (r) begin
         m_total = 0; m_presc = 0; m_mode = M_IDLE; m_lap = 0; m_frozen = 0;
      end else if (c) begin
         m_total = 0; m_presc = 0; m_mode = M_IDLE; m_lap = 0;
      end else begin
         if (m_mode == M_RUN && p) begin
            m_mode = M_PAUSE;
         end else if (m_mode == M_RUN) begin
            if (m_presc == C - 1) begin
               m_presc = 0;
               if (m_total == 99 * 60 + 59) m_mode = M_FULL;
               else                        m_total++;
            end else begin
               m_presc++;
            end
         end else if (m_mode == M_PAUSE && s && !p) begin
            m_mode = M_RUN;
         end else if (m_mode == M_IDLE && s && !p) begin
            m_mode  = M_RUN;
            m_presc = 0;
         end
         if (l && m_lap) begin
            m_lap = 0;
         end else if (freeze_on) begin
            m_lap    = 1;
            m_frozen = old_total;
         end
      end
   endtask

   task automatic step(input bit s, input bit p, input bit c, input bit l, input bit r);
      start = s; stop = p; clear = c; lap = l; rst = r;
      @(posedge clk);
      model_step(s, p, c, l, r);
      #1;
      check("digits", {16'h0, min_hi, min_lo, sec_hi, sec_lo},
            {16'h0, secs_to_digits(m_lap ? m_frozen : m_total)});
      check("flags", {29'h0, running, lap_active, full},
            {29'h0, m_mode == M_RUN, m_lap, m_mode == M_FULL});
      start = 0; stop = 0; clear = 0; lap = 0; rst = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("reset_digits", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0000);

      // First second boundary COUNT edges after start.
      step(1, 0, 0, 0, 0);
      check("running_after_start", running, 1'b1);
      idle(3);
      check("before_first_tick", sec_lo, 4'd0);
      idle(1);
      check("first_tick", sec_lo, 4'd1);
      idle(4);
      check("second_tick", sec_lo, 4'd2);

      // Pause/resume keeps the fractional second.
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(6);
      step(0, 1, 0, 0, 0);
      idle(10);
      step(1, 0, 0, 0, 0);
      idle(1);
      check("resume_pre", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0001);
      idle(1);
      check("resume_tick", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0002);

      // Lap freeze while the live count continues.
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(12);
      step(0, 0, 0, 1, 0);
      idle(8);
      check("lap_hold", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0003);
      step(0, 0, 0, 1, 0);
      check("lap_release", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0005);

      // Simultaneous commands.
      step(1, 0, 1, 0, 0);
      check("clear_start_run", running, 1'b0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("stop_start_pause", running, 1'b0);
      step(1, 0, 0, 0, 0);
      idle(5);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      check("rst_in_lap", {lap_active, min_hi, min_lo, sec_hi, sec_lo}, 17'h0);

      // Run through minute rollover to saturation.
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(60 * C);
      check("minute_carry", {min_hi, min_lo, sec_hi, sec_lo}, 16'h0100);
      idle((5999 - 60) * C);
      check("at_9959", {min_hi, min_lo, sec_hi, sec_lo}, 16'h9959);
      check("not_full_yet", full, 1'b0);
      idle(C);
      check("full_set", {running, full}, 2'b01);
      step(1, 0, 0, 0, 0);
      idle(2 * C);
      check("full_ignores_start", {running, full, min_hi, min_lo, sec_hi, sec_lo}, 18'h19959);
      step(0, 0, 1, 0, 0);
      check("clear_from_full", {running, full, min_hi, min_lo, sec_hi, sec_lo}, 18'h0);

      // Random command mix.
      for (int i = 0; i < 5000; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 499) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch.md
# stopwatch

Count-up elapsed-time counter that measures time rather than spending it, complementing the countdown timer in the same game/controller design. Pulse commands start, pause, clear and lap-freeze the count. It outputs minutes:seconds as four BCD digits for the seven-segment display scanner, up to 99:59, and saturates there.

## Interface
- COUNT, 100_000_000, clk cycles per elapsed second (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin or resume counting
- stop  in  1  one-cycle pulse: pause counting
- clear  in  1  one-cycle pulse: return to 00:00, idle
- lap  in  1  one-cycle pulse: toggle display freeze
- sec_lo  out  4  BCD seconds units (0–9)
- sec_hi  out  4  BCD seconds tens (0–5)
- min_lo  out  4  BCD minutes units (0–9)
- min_hi  out  4  BCD minutes tens (0–9)
- running  out  1  high while in RUN
- lap_active  out  1  high while display is frozen
- full  out  1  high in FULL (saturated at 99:59)

## Operation
- Reset is synchronous and active-high, named rst; clk is the only clock.
- States: IDLE (00:00, not counting), RUN, PAUSE, FULL.
- Command priority in one cycle: rst > clear > stop > start > lap. Lower-priority commands in the same cycle are ignored, except lap (see below).
- IDLE: start → RUN with prescaler = 0. stop and lap are ignored.
- RUN: stop → PAUSE. start is ignored. A tick occurs when prescaler == COUNT-1: prescaler → 0 and the time increments by one second.
- PAUSE: start → RUN. The prescaler holds its value across the pause, so no fractional second is lost or gained. stop is ignored.
- clear in any state → IDLE, digits 0, prescaler 0, lap_active 0.
- Increment is a BCD cascade:
  - sec_lo 9→0 carries into sec_hi.
  - sec_hi 5→0 carries into min_lo.
  - min_lo 9→0 carries into min_hi.
- Saturation: a tick while the live value is 99:59 leaves the value at 99:59 and moves to FULL. In FULL, full=1 and running=0, and start, stop and tick are ignored. Only clear or rst exits FULL.
- Lap:
  - lap with lap_active=0, state RUN, no higher-priority command in the same cycle: latch the live digits, set lap_active=1.
  - lap with lap_active=1, any state: set lap_active=0.
  - All other lap pulses are ignored.
  - While lap_active=1, the outputs show the latched digits; the live count continues unaffected.
- Live digits never hold a non-BCD value; sec_hi never exceeds 5.

## Timing
- Reset values: all digits 0, running 0, lap_active 0, full 0, state IDLE, prescaler 0, latch 0.
- All outputs are registered, and every state update appears in the cycle after the command edge.
  - start sampled at edge N → running=1 after edge N.
  - From IDLE, the first increment is visible after edge N+COUNT. Subsequent increments follow every COUNT cycles.
- Resume after a pause of P cycles: the second boundary shifts by exactly P cycles.
- The FULL transition and full=1 appear in the same cycle the saturating tick would have updated the digits.
- A tick coincident with stop: stop wins. No increment occurs and the prescaler holds.
- A tick coincident with lap: the latch captures the pre-increment value.
- rst asserted mid-count: every register returns to its reset value at the next edge, regardless of commands.

## Test plan
- COUNT=4: rst, then start at cycle 0 → sec_lo=1 after edge 4, 2 after edge 8; running=1 throughout.
- COUNT=4: start, stop after 6 cycles (00:01, prescaler 2), idle 10 cycles, start → 00:02 exactly 2 cycles after the resume edge.
- COUNT=2: run from 00:00 for 119 ticks → digits go 0,0,5,9 → 0,1,0,0 → … → 01:59; confirm the seconds-tens rollover 59→00 with carry into minutes.
- COUNT=2: preload by running to 99:58, then two more ticks → 99:59, then full=1, running=0. start is ignored; clear → 00:00, IDLE.
- COUNT=4 in RUN: lap at 00:03 → outputs hold 00:03 for 8 cycles while the live count reaches 00:05. lap again → outputs show 00:05 next cycle.
- Simultaneous commands:
  - clear+start in RUN → IDLE, 00:00, running=0.
  - stop+start in RUN → PAUSE.
  - rst during lap freeze → all outputs 0.
